// File: rtl/mont_host_sequencer_if.sv
// Host and core-wrapper signal bundle for mont_host_sequencer.
// master = sequencer side, slave = host plus wrapper side.
interface mont_host_sequencer_if #(
  parameter int WORD_LEN = 512
);
  logic                start;
  logic [WORD_LEN-1:0] a_in;
  logic [WORD_LEN-1:0] b_in;
  logic [WORD_LEN-1:0] m_in;
  logic                busy;
  logic                done;
  logic                error;
  logic [WORD_LEN-1:0] result;

  logic [31:0]         port1_din;
  logic                port1_valid;
  logic                port1_read;
  logic                port2_valid;
  logic                port2_read;

  logic [WORD_LEN-1:0] bram_din1;
  logic                bram_din_valid;
  logic [WORD_LEN-1:0] bram_dout1;
  logic                bram_dout1_valid;
  logic                bram_dout_read;

  modport master (
    input  start, a_in, b_in, m_in,
    input  port1_read, port2_valid,
    input  bram_dout1, bram_dout1_valid,
    output busy, done, error, result,
    output port1_din, port1_valid, port2_read,
    output bram_din1, bram_din_valid, bram_dout_read
  );

  modport slave (
    output start, a_in, b_in, m_in,
    output port1_read, port2_valid,
    output bram_dout1, bram_dout1_valid,
    input  busy, done, error, result,
    input  port1_din, port1_valid, port2_read,
    input  bram_din1, bram_din_valid, bram_dout_read
  );
endinterface

// File: rtl/mont_host_sequencer.sv
// Drives the Montgomery core wrapper: load A/B/M, compute, write back.
// Define MONT_SEQ_TIMEOUT_EN to bound every wait state by TIMEOUT_CYCLES.
module mont_host_sequencer #(
  parameter int WORD_LEN = 512
`ifdef MONT_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1 << 20
`endif
) (
  input logic                   clk,
  input logic                   rst,
  mont_host_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_BRAMW,
    S_ACK,
    S_ACKR,
    S_RES,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [WORD_LEN-1:0] a_q, a_d;
  logic [WORD_LEN-1:0] b_q, b_d;
  logic [WORD_LEN-1:0] m_q, m_d;
  logic [WORD_LEN-1:0] res_q, res_d;
  logic                cap_q, cap_d;
  logic [1:0]          rd_q, rd_d;

  logic                p1_valid;
  logic                p2_read;
  logic                din_valid;
  logic [WORD_LEN-1:0] din;
  logic                done;
  logic                error;
  logic                abort;
  logic                res_phase;
  logic                capture;

`ifdef MONT_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;
`endif

  // Write-back data is only trusted while cmd 5 is in flight.
  assign res_phase = (cmd_q == 3'd5) &&
    (state_q inside {S_CMD, S_ACK, S_ACKR, S_RES});
  assign capture = res_phase && !cap_q &&
    bus.bram_dout1_valid;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    res_d     = res_q;
    cap_d     = cap_q;
    rd_d      = (rd_q != 2'd0) ? rd_q - 2'd1 : 2'd0;
    p1_valid  = 1'b0;
    p2_read   = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    done      = 1'b0;
    error     = 1'b0;
    abort     = 1'b0;

    if (capture) begin
      res_d = bus.bram_dout1;
      cap_d = 1'b1;
      rd_d  = 2'd2;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          m_d     = bus.m_in;
          cmd_d   = 3'd1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        p1_valid = 1'b1;
        if (bus.port1_read) begin
          state_d = (cmd_q <= 3'd3) ? S_BRAMW : S_ACK;
        end
      end
      S_BRAMW: begin
        din_valid = 1'b1;
        unique case (1'b1)
          cmd_q == 3'd1: din = a_q;
          cmd_q == 3'd2: din = b_q;
          default:       din = m_q;
        endcase
        state_d = S_ACK;
      end
      S_ACK: begin
        if (bus.port2_valid) begin
          p2_read = 1'b1;
          state_d = S_ACKR;
        end
      end
      S_ACKR: begin
        p2_read = 1'b1;
        if (cmd_q == 3'd5) begin
          state_d = S_RES;
        end else begin
          cmd_d   = cmd_q + 3'd1;
          state_d = S_CMD;
        end
      end
      S_RES: begin
        if (cap_q && rd_q == 2'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        cap_d   = 1'b0;
        cmd_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MONT_SEQ_TIMEOUT_EN
    waiting = state_q inside {S_CMD, S_ACK, S_RES};
    if (waiting && state_d == state_q &&
        cnt_q == TO_LAST) begin
      abort     = 1'b1;
      state_d   = S_IDLE;
      cmd_d     = 3'd0;
      res_d     = res_q;
      cap_d     = 1'b0;
      rd_d      = 2'd0;
      p1_valid  = 1'b0;
      p2_read   = 1'b0;
      din_valid = 1'b0;
      din       = '0;
      done      = 1'b1;
      error     = 1'b1;
    end
    cnt_d = (state_d != state_q || !waiting) ?
      '0 : cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      cap_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      res_q   <= res_d;
      cap_q   <= cap_d;
      rd_q    <= rd_d;
    end
  end

`ifdef MONT_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = done;
  assign bus.error          = error;
  assign bus.result         = res_q;
  assign bus.port1_valid    = p1_valid;
  assign bus.port1_din      = p1_valid ?
    {29'd0, cmd_q} : 32'd0;
  assign bus.port2_read     = p2_read;
  assign bus.bram_din_valid = din_valid;
  assign bus.bram_din1      = din;
  assign bus.bram_dout_read = (rd_q != 2'd0) && !abort;

endmodule

// File: tb/tb_mont_host_sequencer.sv
// Scoreboard bench for mont_host_sequencer with a scripted wrapper model.
// The timeout scenario runs only when MONT_SEQ_TIMEOUT_EN is defined.
module tb_mont_host_sequencer;
  localparam int W = 512;
  typedef logic [W-1:0] word_t;
  typedef struct {
    logic [31:0] cmd;
    int          hold;
  } cmd_exp_t;
  typedef struct {
    logic  err;
    word_t res;
    int    runs;
  } done_exp_t;

  localparam word_t A  = {32'hfdfb53ef,
    {7{64'h1f2e3d4c5b6a7988}}, 32'h7a3e4123};
  localparam word_t B  = {32'hc0b26561,
    {7{64'h0a1b2c3d4e5f6071}}, 32'h5c2d1086};
  localparam word_t M  = {32'hc10b8c94,
    {7{64'h93e8a1c7d2f0b465}}, 32'h8e71240d};
  localparam word_t R  = {32'h01a3c6ff,
    {7{64'h6d0e2f3a4b5c7d8e}}, 32'h4f90db01};
  localparam word_t A2 = {16{32'h11112222}};
  localparam word_t B2 = {16{32'h33334444}};
  localparam word_t M2 = {16{32'h55556667}};
  localparam word_t R2 = {16{32'h2468ace0}};
  localparam word_t R3 = {16{32'h5a5a0f0f}};
  localparam word_t JK = {16{32'hdeadbeef}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mont_host_sequencer_if #(.WORD_LEN(W)) bus ();

  mont_host_sequencer #(
    .WORD_LEN(W)
`ifdef MONT_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  cmd_exp_t  cmd_q[$];
  word_t     bram_q[$];
  done_exp_t done_q[$];

  int    delay2    = 0;
  int    p2_lat    = 3;
  int    p2_lat4   = 3;
  int    p2_lat5   = 3;
  bit    dout_early = 1'b0;
  bit    spurious  = 1'b0;
  bit    p2_never4 = 1'b0;
  word_t model_res = '0;

  task automatic check(input string name,
                       input word_t act,
                       input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not as expected", name);
  endtask

  // Scripted core wrapper: reacts to the sequencer one step per cycle.
  initial begin : wrapper_model
    logic [31:0] cur;
    logic        p1_seen, p2r_seen, rd_seen;
    int          dly, p2_cnt;
    cur = 0; p1_seen = 0; dly = 0; p2_cnt = 0;
    bus.port1_read       = 1'b0;
    bus.port2_valid      = 1'b0;
    bus.bram_dout1       = '0;
    bus.bram_dout1_valid = 1'b0;
    forever begin
      @(negedge clk);
      p2r_seen = bus.port2_read;
      rd_seen  = bus.bram_dout_read;
      @(posedge clk);
      #1;
      if (rst) begin
        cur = 0; p1_seen = 0; dly = 0; p2_cnt = 0;
        bus.port1_read       = 1'b0;
        bus.port2_valid      = 1'b0;
        bus.bram_dout1       = '0;
        bus.bram_dout1_valid = 1'b0;
        continue;
      end
      if (p2r_seen) bus.port2_valid = 1'b0;
      if (rd_seen) begin
        bus.bram_dout1_valid = 1'b0;
        bus.bram_dout1       = '0;
      end
      if (p2_cnt > 0) begin
        p2_cnt--;
        if (p2_cnt == 0) begin
          bus.port2_valid = 1'b1;
          if (cur == 5 && !dout_early) begin
            bus.bram_dout1_valid = 1'b1;
            bus.bram_dout1       = model_res;
          end
        end
      end
      if (bus.port1_valid) begin
        if (!p1_seen) begin
          p1_seen = 1'b1;
          cur     = bus.port1_din;
          dly     = (cur == 2) ? delay2 : 0;
        end
        if (dly == 0) begin
          bus.port1_read = 1'b1;
          if (cur == 4) p2_cnt = p2_never4 ? 0 : p2_lat4;
          else if (cur == 5) p2_cnt = p2_lat5;
          else p2_cnt = p2_lat;
          if (cur == 5 && dout_early) begin
            bus.bram_dout1_valid = 1'b1;
            bus.bram_dout1       = model_res;
          end
          if (cur == 2 && spurious) begin
            bus.bram_dout1_valid = 1'b1;
            bus.bram_dout1       = JK;
          end
          if (cur == 3 && spurious) begin
            bus.bram_dout1_valid = 1'b0;
            bus.bram_dout1       = '0;
          end
        end else begin
          bus.port1_read = 1'b0;
          dly--;
        end
      end else begin
        p1_seen        = 1'b0;
        bus.port1_read = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic        prev_v, prev_acc;
    logic [31:0] prev_din;
    int          hold, p2r_run, rd_run, rd_runs;
    cmd_exp_t    ce;
    done_exp_t   de;
    prev_v = 0; prev_acc = 0; prev_din = 0;
    hold = 0; p2r_run = 0; rd_run = 0; rd_runs = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0; prev_acc = 0; hold = 0;
        p2r_run = 0; rd_run = 0; rd_runs = 0;
        continue;
      end
      if (!bus.port1_valid) begin
        check("p1_din_idle", bus.port1_din, 0);
      end else begin
        if (prev_v && !prev_acc)
          check("p1_din_stable", bus.port1_din, prev_din);
        if (bus.port1_read) begin
          if (cmd_q.size() == 0) begin
            flag("p1_unexpected_cmd");
          end else begin
            ce = cmd_q.pop_front();
            check("p1_cmd", bus.port1_din, ce.cmd);
            check("p1_hold", hold, ce.hold);
          end
          hold = 0;
        end else begin
          hold++;
        end
      end
      if (!bus.bram_din_valid) begin
        check("bram_din_idle", bus.bram_din1, 0);
      end else begin
        check("bram_after_accept", prev_acc, 1);
        if (bram_q.size() == 0) flag("bram_unexpected");
        else check("bram_data", bus.bram_din1,
                   bram_q.pop_front());
      end
      prev_v   = bus.port1_valid;
      prev_acc = bus.port1_valid && bus.port1_read;
      prev_din = bus.port1_din;
      if (bus.port2_read) begin
        p2r_run++;
      end else if (p2r_run != 0) begin
        check("p2_read_len", p2r_run, 2);
        p2r_run = 0;
      end
      if (bus.bram_dout_read) begin
        rd_run++;
      end else if (rd_run != 0) begin
        check("dout_read_len", rd_run, 2);
        rd_run = 0;
        rd_runs++;
      end
      if (bus.error) begin
        check("error_needs_done", bus.done, 1);
        check("abort_p1_valid", bus.port1_valid, 0);
        check("abort_p2_read", bus.port2_read, 0);
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          flag("done_unexpected");
        end else begin
          de = done_q.pop_front();
          check("done_error", bus.error, de.err);
          check("result", bus.result, de.res);
          check("dout_read_runs", rd_runs, de.runs);
        end
        rd_runs = 0;
      end
    end
  end

  task automatic expect_done(input logic err,
                             input word_t res,
                             input int runs);
    done_exp_t d;
    d.err  = err;
    d.res  = res;
    d.runs = runs;
    done_q.push_back(d);
  endtask

  task automatic launch(input word_t a, input word_t b,
                        input word_t m, input int hold2,
                        input int last);
    cmd_exp_t e;
    for (int c = 1; c <= last; c++) begin
      e.cmd  = c;
      e.hold = (c == 2) ? hold2 : 0;
      cmd_q.push_back(e);
    end
    bram_q.push_back(a);
    bram_q.push_back(b);
    bram_q.push_back(m);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.m_in  = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.m_in  = '0;
    @(negedge clk);
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) flag("done_timeout");
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
  endtask

  task automatic wait_cmd(input int c, input bit acc,
                          input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = bus.port1_valid &&
            bus.port1_din == 32'(c) &&
            (!acc || bus.port1_read);
    end
    if (!hit) flag("wait_cmd_timeout");
  endtask

  task automatic check_idle(input string t);
    check({t, "_busy"}, bus.busy, 0);
    check({t, "_done"}, bus.done, 0);
    check({t, "_error"}, bus.error, 0);
    check({t, "_result"}, bus.result, 0);
    check({t, "_p1_valid"}, bus.port1_valid, 0);
    check({t, "_p1_din"}, bus.port1_din, 0);
    check({t, "_p2_read"}, bus.port2_read, 0);
    check({t, "_din_valid"}, bus.bram_din_valid, 0);
    check({t, "_din1"}, bus.bram_din1, 0);
    check({t, "_dout_read"}, bus.bram_dout_read, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.m_in  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // Plain run
    model_res = R;
    expect_done(1'b0, R, 1);
    launch(A, B, M, 0, 5);
    wait_done(300);

    // Second start while busy must be ignored
    expect_done(1'b0, R, 1);
    launch(A, B, M, 0, 5);
    wait_cmd(3, 1'b0, 100);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a_in  = A2;
    bus.b_in  = B2;
    bus.m_in  = M2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.m_in  = '0;
    wait_done(300);

    // Slow acceptance of cmd 2
    delay2 = 7;
    expect_done(1'b0, R, 1);
    launch(A, B, M, 7, 5);
    wait_done(300);
    delay2 = 0;

    // Early write-back data plus stray data during cmd 2
    dout_early = 1'b1;
    spurious   = 1'b1;
    p2_lat5    = 6;
    model_res  = R3;
    expect_done(1'b0, R3, 1);
    launch(A, B, M, 0, 5);
    wait_done(300);
    dout_early = 1'b0;
    spurious   = 1'b0;
    p2_lat5    = 3;

    // Reset while waiting in ACK of cmd 4
    p2_lat4 = 20;
    launch(A, B, M, 0, 4);
    wait_cmd(4, 1'b1, 100);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    p2_lat4 = 3;

    model_res = R2;
    expect_done(1'b0, R2, 1);
    launch(A2, B2, M2, 0, 5);
    wait_done(300);

`ifdef MONT_SEQ_TIMEOUT_EN
    p2_never4 = 1'b1;
    expect_done(1'b1, R2, 0);
    launch(A, B, M, 0, 4);
    wait_cmd(4, 1'b1, 100);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
    end
    check("timeout_cycle", n, 16);
    check("timeout_error", bus.error, 1);
    @(negedge clk);
    check("busy_after_timeout", bus.busy, 0);
    p2_never4 = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("cmd_left", cmd_q.size(), 0);
    check("bram_left", bram_q.size(), 0);
    check("done_left", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_host_sequencer.md
MONT_HOST_SEQUENCER -- requirements
Module: mont_host_sequencer

Interface
REQ-001 WORD_LEN, default 512, operand/result width in bits.
REQ-002 TIMEOUT_CYCLES, default 2^20, maximum cycles per wait state when the timeout is compiled in.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to run a full modular multiplication.
REQ-006 a_in, b_in, m_in  in  WORD_LEN each  operands; sampled only on the accepted start cycle.
REQ-007 busy  out  1  high from the cycle after start is accepted until done.
REQ-008 done  out  1  one-cycle pulse at end of sequence.
REQ-009 error  out  1  one-cycle pulse with done on timeout abort.
REQ-010 result  out  WORD_LEN  captured product; holds until the next capture.
REQ-011 port1_din  out  32  command word to the core wrapper.
REQ-012 port1_valid  out  1  command valid.
REQ-013 port1_read  in  1  wrapper accepted command.
REQ-014 port2_valid  in  1  wrapper reports command complete.
REQ-015 port2_read  out  1  completion acknowledge.
REQ-016 bram_din1  out  WORD_LEN  operand data to wrapper.
REQ-017 bram_din_valid  out  1  operand data strobe.
REQ-018 bram_dout1  in  WORD_LEN  result data from wrapper.
REQ-019 bram_dout1_valid  in  1  result data valid; level, held until bram_dout_read.
REQ-020 bram_dout_read  out  1  result data acknowledge.

Function
REQ-021 Sequence SHALL be: CMD 1 + A, CMD 2 + B, CMD 3 + M, CMD 4 (compute), CMD 5 (write-back); port1_din = 32'h1..32'h5 respectively.
REQ-022 States: IDLE, CMD, BRAMW, ACK, ACKR, RES, DONE.
REQ-023 IDLE: start=1 latches operands, sets busy, enters CMD with cmd=1 next cycle; start while busy SHALL be ignored.
REQ-024 CMD: port1_valid=1, port1_din=cmd held stable until port1_read sampled 1; then port1_valid=0 next cycle and go BRAMW (cmd 1-3) or ACK (cmd 4-5).
REQ-025 BRAMW: bram_din_valid=1 for exactly one cycle with bram_din1 = A/B/M per cmd; then ACK.
REQ-026 ACK: wait port2_valid=1; then port2_read=1 for exactly 2 cycles (ACK exit cycle + ACKR), then port2_read=0.
REQ-027 After ACKR: cmd<5 increments cmd and returns to CMD; cmd=5 goes to RES.
REQ-028 Result capture: during cmd-5 CMD/ACK/ACKR/RES, first cycle bram_dout1_valid=1 loads result and sets captured flag; bram_dout_read=1 for exactly 2 cycles from the following cycle.
REQ-029 RES: waits until captured flag set and bram_dout_read pulse finished; then DONE.
REQ-030 DONE: done=1 one cycle, busy=0 next cycle, return to IDLE, clear flag.
REQ-031 bram_din1 SHALL be 0 whenever bram_din_valid=0; port1_din 0 whenever port1_valid=0.
REQ-032 bram_dout1_valid outside cmd-5 phase SHALL be ignored (no capture, no read).

Reset
REQ-033 reset=1 SHALL force IDLE immediately; all outputs 0, result 0, flag/cmd/counter 0.
REQ-034 Reset mid-sequence SHALL abort with no done/error pulse; next start restarts from cmd 1.

Configuration
REQ-035 Macro MONT_SEQ_TIMEOUT_EN defined: counter clears on each state entry, increments in CMD/ACK/RES; reaching TIMEOUT_CYCLES drops all handshake outputs, pulses done=1 and error=1 together, returns to IDLE, result unchanged.
REQ-036 Macro undefined: no counter, waits are unbounded, error tied 0.

Verification
REQ-037 Normal run with behavioural wrapper model, A=fdfb53ef…4123, B=c0b26561…1086, M=c10b8c94…240d -> port1_din sequence 1,2,3,4,5, three single-cycle bram_din_valid strobes, done once, result=01a3c6ff…db01.
REQ-038 Model delays port1_read 7 cycles on cmd 2 -> port1_valid/port1_din=2 held stable all 7 cycles, no bram strobe before acceptance.
REQ-039 Model raises bram_dout1_valid before port2_valid on cmd 5 -> result captured once, bram_dout_read exactly 2 cycles, done after ACKR.
REQ-040 start pulsed during cmd 3 with different operands -> ignored; result unchanged from REQ-037 value.
REQ-041 reset asserted in ACK of cmd 4 -> all outputs 0 same cycle; subsequent start completes normally.
REQ-042 With MONT_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never asserts port2_valid on cmd 4 -> done=error=1 on cycle 16 of ACK, busy=0 next cycle.
